jvm_mem_arbiter: RTL and testbench

- Two-requester round-robin arbiter/sequencer in front of the single-port byte-wide jvm_memory.
- Requester 0 is bytecode fetch and requester 1 is the operand/local data path.
- The block serialises their accesses, drives the memory start/rwn/address/data handshake and waits on memory ready, since memory latency is variable and address-dependent in simulation builds.
- It returns read data and a one-cycle done pulse to the granted requester.

---
 rtl/jvm_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_jvm_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jvm_mem_arbiter.sv
// jvm_mem_arbiter: two-requester round-robin sequencer in front of the
// single-port byte-wide jvm_memory. Requester 0 is bytecode fetch and
// requester 1 is the operand/local data path. One access is in flight at a
// time. Memory latency is variable, so the block waits on mem_ready.
// Optional feature macro: JVM_MEM_ARB_WDOG_EN adds a BUSY-state watchdog.
// The watchdog aborts a hung access with done+err and then parks the arbiter
// until reset.
module jvm_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int WDOG_CYCLES   = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     rwn0,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [7:0]               wdata0,
  output logic                     done0,
  input  logic                     req1,
  input  logic                     rwn1,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [7:0]               wdata1,
  output logic                     done1,
  output logic [7:0]               rdata,
  output logic                     err,
  output logic                     mem_start,
  output logic                     mem_rwn,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [7:0]               mem_data_in,
  input  logic [7:0]               mem_data_out,
  input  logic                     mem_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t state;
  logic   last_grant;  // requester granted most recently (1 after reset so 0 wins first tie)
  logic   grant;       // requester owning the access in flight
  logic   busy_first;  // high during the first BUSY cycle, when mem_ready is still stale
  logic   pick;        // arbitration winner for the current IDLE cycle
  logic   can_issue;

  // The watchdog limit has to fit the 4-bit counter. This empty block appears
  // in the elaborated hierarchy only when the setting is out of range.
  if (WDOG_CYCLES < 1 || WDOG_CYCLES > 15) begin : g_wdog_cycles_out_of_range
  end

`ifdef JVM_MEM_ARB_WDOG_EN
  logic [3:0] wdog_count;
  logic       hung;      // sticky after an abort; cleared only by reset
`else
  assign err = 1'b0;
`endif

  // Round robin: a lone request wins. On a tie, the requester not granted last time wins.
  always_comb begin
    if (req0 && req1) pick = ~last_grant;
    else              pick = req1;
  end

  // A new access may start only when someone asks and the memory is idle.
  always_comb begin
    can_issue = (req0 | req1) & mem_ready;
`ifdef JVM_MEM_ARB_WDOG_EN
    if (hung) can_issue = 1'b0;
`endif
  end

  // Sequencer FSM. All outputs are registered. Pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      busy_first  <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      mem_start   <= 1'b0;
      mem_rwn     <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rdata       <= '0;
`ifdef JVM_MEM_ARB_WDOG_EN
      err         <= 1'b0;
      wdog_count  <= '0;
      hung        <= 1'b0;
`endif
    end else begin
      done0     <= 1'b0;
      done1     <= 1'b0;
      mem_start <= 1'b0;
`ifdef JVM_MEM_ARB_WDOG_EN
      err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (can_issue) begin
            grant       <= pick;
            last_grant  <= pick;
            mem_rwn     <= pick ? rwn1 : rwn0;
            mem_address <= pick ? addr1 : addr0;
            mem_data_in <= pick ? wdata1 : wdata0;
            mem_start   <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          busy_first <= 1'b1;
`ifdef JVM_MEM_ARB_WDOG_EN
          wdog_count <= '0;
`endif
          state      <= BUSY;
        end
        BUSY: begin
          busy_first <= 1'b0;
          if (!busy_first && mem_ready) begin
            if (mem_rwn) rdata <= mem_data_out;
            if (grant) done1 <= 1'b1;
            else       done0 <= 1'b1;
            state <= RESP;
          end
`ifdef JVM_MEM_ARB_WDOG_EN
          else if (wdog_count == 4'(WDOG_CYCLES - 1)) begin
            // The memory never came back. Complete with an error and stop issuing.
            if (grant) done1 <= 1'b1;
            else       done0 <= 1'b1;
            err   <= 1'b1;
            hung  <= 1'b1;
            state <= RESP;
          end else begin
            wdog_count <= wdog_count + 4'd1;
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jvm_mem_arbiter.sv
// Self-checking bench for jvm_mem_arbiter (default build, watchdog disabled).
// A behavioural memory stub has address-dependent latency (addr % 6 extra
// cycles). A transaction-level reference model predicts, for each access, the
// issue cycle and the completion cycle from plain arithmetic. One compare
// process checks every DUT output against the model on each cycle.
module tb_jvm_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_v   [2];
  logic       rwn_v   [2];
  logic [7:0] addr_v  [2];
  logic [7:0] wdata_v [2];
  logic       done0, done1, err, mem_start, mem_rwn, mem_ready;
  logic [7:0] rdata, mem_address, mem_data_in, mem_data_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  jvm_mem_arbiter #(.ADDRESS_WIDTH(8), .WDOG_CYCLES(15)) dut (
    .clk(clk), .reset(reset),
    .req0(req_v[0]), .rwn0(rwn_v[0]), .addr0(addr_v[0]), .wdata0(wdata_v[0]), .done0(done0),
    .req1(req_v[1]), .rwn1(rwn_v[1]), .addr1(addr_v[1]), .wdata1(wdata_v[1]), .done1(done1),
    .rdata(rdata), .err(err),
    .mem_start(mem_start), .mem_rwn(mem_rwn), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ready(mem_ready)
  );

  function automatic int mem_delay(input logic [7:0] a);
    return int'(a) % 6;
  endfunction

  function automatic logic [7:0] mem_init(input int i);
    if (i == 8'h12) return 8'hA5;
    return 8'(((i * 37) + 11) ^ 'h5A);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
  endtask

  // ---------------- memory stub ----------------
  logic [7:0] smem [256];
  logic       s_ready = 1'b1;
  int         s_cnt = 0;
  bit         s_inited = 1'b0;
  logic [7:0] s_dout = 8'h00;
  assign mem_ready    = s_ready;
  assign mem_data_out = s_dout;

  always @(posedge clk) begin
    if (!s_inited) begin
      for (int i = 0; i < 256; i++) smem[i] <= mem_init(i);
      s_inited <= 1'b1;
    end
    if (reset) begin
      s_ready <= 1'b1;
      s_cnt   <= 0;
    end else if (mem_start && s_ready) begin
      s_ready <= 1'b0;
      s_cnt   <= mem_delay(mem_address);
      if (mem_rwn) s_dout <= smem[mem_address];
      else         smem[mem_address] <= mem_data_in;
    end else if (!s_ready) begin
      if (s_cnt == 0) s_ready <= 1'b1;
      else            s_cnt <= s_cnt - 1;
    end
  end

  // ---------------- transaction-level reference model ----------------
  // cyc numbers the clock intervals: interval k follows posedge k. An access
  // granted at posedge p has ISSUE in interval p and done in interval p+3+d.
  // The next grant is possible at posedge p+5+d.
  bit         started = 1'b0;
  int         cyc = 0;
  logic [7:0] ref_mem [256];
  int         m_issue = -100, m_done_at = -100, m_free_at = 0;
  logic       m_grant = 1'b0, m_last = 1'b1, m_rwn = 1'b0;
  logic [7:0] m_addr = 8'h00, m_wd = 8'h00, m_rdata = 8'h00, m_pend = 8'h00;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      if (!started) for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
      started   = 1'b1;
      m_issue   = -100;
      m_done_at = -100;
      m_free_at = cyc + 1;
      m_last    = 1'b1;
      m_rwn     = 1'b0;
      m_addr    = 8'h00;
      m_wd      = 8'h00;
      m_rdata   = 8'h00;
    end else if (started) begin
      if (cyc == m_issue + 1) begin
        if (m_rwn) m_pend = ref_mem[m_addr];
        else       ref_mem[m_addr] = m_wd;
      end
      if (cyc == m_done_at && m_rwn) m_rdata = m_pend;
      if (cyc >= m_free_at && (req_v[0] || req_v[1])) begin
        m_grant   = (req_v[0] && req_v[1]) ? !m_last : req_v[1];
        m_last    = m_grant;
        m_rwn     = rwn_v[m_grant];
        m_addr    = addr_v[m_grant];
        m_wd      = wdata_v[m_grant];
        m_issue   = cyc;
        m_done_at = cyc + 3 + mem_delay(m_addr);
        m_free_at = cyc + 5 + mem_delay(m_addr);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_start = 0, n_d0 = 0, n_d1 = 0;
  always @(negedge clk) begin
    if (started) begin
      chk("mem_start",   int'(mem_start),   int'(cyc == m_issue));
      chk("done0",       int'(done0),       int'(cyc == m_done_at && !m_grant));
      chk("done1",       int'(done1),       int'(cyc == m_done_at && m_grant));
      chk("err",         int'(err),         0);
      chk("rdata",       int'(rdata),       int'(m_rdata));
      chk("mem_rwn",     int'(mem_rwn),     int'(m_rwn));
      chk("mem_address", int'(mem_address), int'(m_addr));
      chk("mem_data_in", int'(mem_data_in), int'(m_wd));
      if (mem_start) n_start++;
      if (done0) n_d0++;
      if (done1) n_d1++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_done0", int'(done0), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_start", int'(mem_start), 0);
    chk("rst_addr",  int'(mem_address), 0);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_rwn_din", int'({mem_rwn, mem_data_in, err}), 0);
  endtask

  task automatic do_access(input int r, input logic rw, input logic [7:0] a, input logic [7:0] wd,
                           output int lat, output logic [7:0] rd);
    int n;
    bit got;
    @(negedge clk);
    req_v[r] = 1'b1; rwn_v[r] = rw; addr_v[r] = a; wdata_v[r] = wd;
    n = 0; got = 1'b0; rd = 8'h00;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if ((r == 0 ? done0 : done1) == 1'b1) begin
        got = 1'b1;
        rd  = rdata;
      end
    end
    req_v[r] = 1'b0;
    chk("access_done", int'(got), 1);
    lat = got ? n : -1;
    $display("access r%0d rwn=%0d addr=%02h wdata=%02h latency=%0d rdata=%02h", r, rw, a, wd, lat, rd);
  endtask

  function automatic logic [7:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return 8'($urandom_range(0, 15));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [7:0] rd;
    int order [4];
    int nd, b_start, b_d1, b_d0;
    int held [2];

    for (int r = 0; r < 2; r++) begin
      req_v[r] = 1'b0; rwn_v[r] = 1'b0; addr_v[r] = 8'h00; wdata_v[r] = 8'h00; held[r] = 0;
    end
    for (int i = 0; i < 4; i++) order[i] = -1;

    // Single read of a preloaded location.
    apply_reset();
    b_start = n_start; b_d1 = n_d1;
    do_access(0, 1'b1, 8'h12, 8'h00, lat, rd);
    chk("read12_latency", lat, 4);
    chk("read12_rdata", int'(rd), 8'hA5);
    chk("read12_start_pulses", n_start - b_start, 1);
    chk("read12_no_done1", n_d1 - b_d1, 0);

    // Write then read back through requester 1.
    do_access(1, 1'b0, 8'h40, 8'h3C, lat, rd);
    chk("write40_rdata_held", int'(rd), 8'hA5);
    do_access(1, 1'b1, 8'h40, 8'h00, lat, rd);
    chk("read40_rdata", int'(rd), 8'h3C);
    chk("read40_latency", lat, 8);

    // Contention: both held from reset, grants must alternate 0,1,0,1.
    apply_reset();
    @(negedge clk);
    req_v[0] = 1'b1; rwn_v[0] = 1'b1; addr_v[0] = rnd_addr();
    req_v[1] = 1'b1; rwn_v[1] = 1'b1; addr_v[1] = rnd_addr();
    nd = 0;
    for (int c = 0; c < 200 && nd < 4; c++) begin
      @(negedge clk);
      if (done0 && done1) chk("done_overlap", 1, 0);
      if (done0 && nd < 4) begin order[nd] = 0; nd++; addr_v[0] = rnd_addr(); end
      if (done1 && nd < 4) begin order[nd] = 1; nd++; addr_v[1] = rnd_addr(); end
    end
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    chk("contention_count", nd, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("grant_order[%0d]", i), order[i], i % 2);

    // Address-dependent latency.
    do_access(0, 1'b1, 8'h03, 8'h00, lat, rd);
    chk("latency_addr03", lat, 7);
    do_access(0, 1'b1, 8'h00, 8'h00, lat, rd);
    chk("latency_addr00", lat, 4);

    // Reset in the middle of a long read.
    @(negedge clk);
    req_v[0] = 1'b1; rwn_v[0] = 1'b1; addr_v[0] = 8'h05;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    req_v[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_done0", int'(done0), 0);
    chk("midrst_start", int'(mem_start), 0);
    chk("midrst_addr", int'(mem_address), 0);
    chk("midrst_rdata", int'(rdata), 0);
    b_d0 = n_d0;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", n_d0 - b_d0, 0);
    do_access(0, 1'b1, 8'h12, 8'h00, lat, rd);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_rdata", int'(rd), 8'hA5);

    // Randomized traffic from both requesters, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (reset) begin
        reset = 1'b0;
        continue;
      end
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        req_v[0] = 1'b0; req_v[1] = 1'b0; held[0] = 0; held[1] = 0;
        continue;
      end
      for (int r = 0; r < 2; r++) begin
        if (req_v[r]) begin
          if ((r == 0 ? done0 : done1) == 1'b1) begin
            held[r] = 0;
            if ($urandom_range(0, 1) == 1) req_v[r] = 1'b0;
            else begin
              rwn_v[r] = 1'($urandom); addr_v[r] = rnd_addr(); wdata_v[r] = 8'($urandom);
            end
          end else begin
            held[r]++;
            if (held[r] > 60) begin
              chk($sformatf("req%0d_wait", r), held[r], 0);
              req_v[r] = 1'b0;
              held[r] = 0;
            end
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req_v[r] = 1'b1; rwn_v[r] = 1'($urandom); addr_v[r] = rnd_addr(); wdata_v[r] = 8'($urandom);
        end
      end
    end
    reset = 1'b0;
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
